// File: rtl/vga_pitch_pkg.sv
// Shared constants and types for the pitch renderer.
// Default timing is 640x480@60 from a 100 MHz clock.
package vga_pitch_pkg;

  localparam int VGA_CLK_DIV  = 4;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOT =
    VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOT =
    VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
  localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [11:0] rgb444_t;

  localparam rgb444_t COL_WHITE = 12'hFFF;
  localparam rgb444_t COL_GREEN = 12'h0F0;
  localparam rgb444_t COL_BLACK = 12'h000;

  function automatic cnt_t clamp_row(
    input logic [8:0] row,
    input int         lim
  );
    cnt_t r;
    r = cnt_t'(row);
    if (int'(r) >= lim) r = cnt_t'(lim - 1);
    return r;
  endfunction

endpackage

// File: rtl/vga_pitch_renderer_if.sv
// Register bank inputs and VGA outputs of the renderer.
// master = register side / sink, slave = renderer.
interface vga_pitch_renderer_if;

  logic [31:0] slv_reg0;
  logic [31:0] slv_reg1;
  logic [31:0] slv_reg2;
  logic [31:0] slv_reg3;
  logic        vga_hsync;
  logic        vga_vsync;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        frame_start;

  modport master (
    output slv_reg0, slv_reg1,
    output slv_reg2, slv_reg3,
    input  vga_hsync, vga_vsync,
    input  vga_r, vga_g, vga_b,
    input  frame_start
  );

  modport slave (
    input  slv_reg0, slv_reg1,
    input  slv_reg2, slv_reg3,
    output vga_hsync, vga_vsync,
    output vga_r, vga_g, vga_b,
    output frame_start
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Pixel strobe divider and h/v raster counters.
// Flags here are combinational from the counters.
module vga_timing_gen
  import vga_pitch_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic ACLK,
  input  logic ARESETN,
  output logic pix_en,
  output cnt_t h,
  output cnt_t v,
  output logic hs_n,
  output logic vs_n,
  output logic active,
  output logic eof
);

  localparam int DIV_W =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int H_TOT =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT =
    V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  logic [DIV_W-1:0] div;

  assign pix_en = (div == DIV_W'(CLK_DIV - 1));

  // divide ACLK down to the pixel strobe
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)    div <= '0;
    else if (pix_en) div <= '0;
    else             div <= div + DIV_W'(1);
  end

  // raster position, one step per pixel strobe
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (h == cnt_t'(H_TOT - 1)) begin
        h <= '0;
        if (v == cnt_t'(V_TOT - 1)) v <= '0;
        else                        v <= v + cnt_t'(1);
      end else begin
        h <= h + cnt_t'(1);
      end
    end
  end

  assign hs_n = !((h >= cnt_t'(HS_START)) &&
                  (h <= cnt_t'(HS_END)));
  assign vs_n = !((v >= cnt_t'(VS_START)) &&
                  (v <= cnt_t'(VS_END)));
  assign active = (h < cnt_t'(H_ACTIVE)) &&
                  (v < cnt_t'(V_ACTIVE));
  assign eof = (h == cnt_t'(H_TOT - 1)) &&
               (v == cnt_t'(V_TOT - 1));

endmodule

// File: rtl/vga_pitch_renderer.sv
// Draws target and detected pitch rows on a VGA raster.
// Register values are latched once per frame to avoid tearing.
module vga_pitch_renderer
  import vga_pitch_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input logic           ACLK,
  input logic           ARESETN,
  vga_pitch_renderer_if.slave bus
);

  logic    pix_en;
  logic    hs_n;
  logic    vs_n;
  logic    active;
  logic    eof;
  cnt_t    h;
  cnt_t    v;

  vga_timing_gen #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .pix_en  (pix_en),
    .h       (h),
    .v       (v),
    .hs_n    (hs_n),
    .vs_n    (vs_n),
    .active  (active),
    .eof     (eof)
  );

  logic [8:0] sh_tgt;
  logic [8:0] sh_det;
  rgb444_t    sh_col;
  logic       sh_en;
  logic [7:0] sh_tol;

  // latch the register bank on the last pixel of a frame
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sh_tgt <= '0;
      sh_det <= '0;
      sh_col <= '0;
      sh_en  <= 1'b0;
      sh_tol <= '0;
    end else if (pix_en && eof) begin
      sh_tgt <= bus.slv_reg0[8:0];
      sh_det <= bus.slv_reg1[8:0];
      sh_col <= bus.slv_reg2[11:0];
      sh_en  <= bus.slv_reg3[0];
      sh_tol <= bus.slv_reg3[15:8];
    end
  end

  cnt_t    tgt;
  cnt_t    det;
  cnt_t    diff;
  logic    in_tol;
  logic    on_tgt;
  logic    on_det;
  logic    sel_tgt;
  logic    sel_det;
  rgb444_t pix;

  assign tgt  = clamp_row(sh_tgt, V_ACTIVE);
  assign det  = clamp_row(sh_det, V_ACTIVE);
  assign diff = (tgt >= det) ? (tgt - det)
                             : (det - tgt);
  assign in_tol = (diff <= cnt_t'(sh_tol));

  assign on_tgt = (v == tgt) ||
                  (v == tgt + cnt_t'(1));
  assign on_det = (v == det) ||
                  (v == det + cnt_t'(1));

  assign sel_tgt = active && sh_en && on_tgt;
  assign sel_det = active && sh_en &&
                   !on_tgt && on_det;

  // target row wins over detected row
  always_comb begin
    pix = COL_BLACK;
    unique case (1'b1)
      sel_tgt: pix = COL_WHITE;
      sel_det: pix = in_tol ? COL_GREEN : sh_col;
      default: pix = COL_BLACK;
    endcase
  end

  rgb444_t rgb;
  logic    hsync;
  logic    vsync;
  logic    fstart;

  // single output stage keeps colour and syncs aligned
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rgb    <= COL_BLACK;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      fstart <= 1'b0;
    end else begin
      fstart <= pix_en && eof;
      if (pix_en) begin
        rgb   <= pix;
        hsync <= hs_n;
        vsync <= vs_n;
      end
    end
  end

  assign bus.vga_r       = rgb[11:8];
  assign bus.vga_g       = rgb[7:4];
  assign bus.vga_b       = rgb[3:0];
  assign bus.vga_hsync   = hsync;
  assign bus.vga_vsync   = vsync;
  assign bus.frame_start = fstart;

  logic unused_bits;
  assign unused_bits = ^{bus.slv_reg0[31:9],
                         bus.slv_reg1[31:9],
                         bus.slv_reg2[31:12],
                         bus.slv_reg3[31:16],
                         bus.slv_reg3[7:1]};

endmodule

// File: tb/tb_vga_pitch_renderer.sv
// Bench for vga_pitch_renderer on a shrunken raster.
// A cycle-indexed model predicts every output each cycle.
module tb_vga_pitch_renderer;

  localparam int CD = 4;
  localparam int HA = 16;
  localparam int HF = 2;
  localparam int HS = 4;
  localparam int HB = 2;
  localparam int VA = 12;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int PIX_FRAME = HT * VT;
  localparam int FRAME_CYC = PIX_FRAME * CD;
  localparam int LIM = 2 * FRAME_CYC + 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  vga_pitch_renderer_if bus();

  vga_pitch_renderer #(
    .CLK_DIV  (CD),
    .H_ACTIVE (HA),
    .H_FP     (HF),
    .H_SYNC   (HS),
    .H_BP     (HB),
    .V_ACTIVE (VA),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB)
  ) dut (
    .ACLK    (clk),
    .ARESETN (rst_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  int m = 0;
  logic [31:0] sh0 = '0;
  logic [31:0] sh1 = '0;
  logic [31:0] sh2 = '0;
  logic [31:0] sh3 = '0;

  // cycles since reset release, plus the model's frame copy
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m   <= 0;
      sh0 <= '0;
      sh1 <= '0;
      sh2 <= '0;
      sh3 <= '0;
    end else begin
      m <= m + 1;
      if ((m + 1) % FRAME_CYC == 0) begin
        sh0 <= bus.slv_reg0;
        sh1 <= bus.slv_reg1;
        sh2 <= bus.slv_reg2;
        sh3 <= bus.slv_reg3;
      end
    end
  end

  function automatic logic [14:0] model_out(input int mm);
    int q, h, v, tgt, det, d;
    logic [11:0] c;
    logic hs_o, vs_o, fs;
    fs = (mm > 0) && (mm % FRAME_CYC == 0);
    if (mm < CD) return {12'h000, 1'b1, 1'b1, fs};
    q = mm / CD - 1;
    h = q % HT;
    v = (q / HT) % VT;
    hs_o = !(h >= HA + HF && h < HA + HF + HS);
    vs_o = !(v >= VA + VF && v < VA + VF + VS);
    c = 12'h000;
    if (h < HA && v < VA && sh3[0]) begin
      tgt = int'(sh0[8:0]);
      det = int'(sh1[8:0]);
      if (tgt > VA - 1) tgt = VA - 1;
      if (det > VA - 1) det = VA - 1;
      d = (tgt > det) ? tgt - det : det - tgt;
      if (v == tgt || v == tgt + 1)
        c = 12'hFFF;
      else if (v == det || v == det + 1)
        c = (d <= int'(sh3[15:8])) ? 12'h0F0
                                   : sh2[11:0];
    end
    return {c, hs_o, vs_o, fs};
  endfunction

  logic [14:0] got_o;
  logic [14:0] exp_o;

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      exp_o = model_out(m);
      got_o = {bus.vga_r, bus.vga_g, bus.vga_b,
               bus.vga_hsync, bus.vga_vsync,
               bus.frame_start};
      tests++;
      if (got_o !== exp_o) begin
        fails++;
        $display("FAIL model cyc=%0d got=%h want=%h",
                 m, got_o, exp_o);
      end
    end
  end

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [11:0] rgb_now();
    return {bus.vga_r, bus.vga_g, bus.vga_b};
  endfunction

  task automatic wait_m(input int target);
    int n;
    n = 0;
    while (m < target && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("wait_m", 32'(m), 32'(target));
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clk);
    while (!(m > 0 && m % FRAME_CYC == 0) && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("frame_start_hi", 32'(bus.frame_start), 32'd1);
    @(negedge clk);
    check("frame_start_lo", 32'(bus.frame_start), 32'd0);
  endtask

  task automatic expect_px(input string nm,
                           input int h, input int v,
                           input logic [11:0] exp);
    int f, target;
    f = m / FRAME_CYC;
    target = CD * (f * PIX_FRAME + v * HT + h + 1);
    if (target <= m) target += FRAME_CYC;
    wait_m(target);
    check(nm, 32'(rgb_now()), 32'(exp));
  endtask

  task automatic sync_shape(input bit vert,
                            output int low,
                            output int per);
    logic cur, prev;
    int t0, t1, t2, n;
    prev = vert ? bus.vga_vsync : bus.vga_hsync;
    t0 = -1;
    t1 = -1;
    t2 = -1;
    n = 0;
    while (t2 < 0 && n < LIM) begin
      @(negedge clk);
      n++;
      cur = vert ? bus.vga_vsync : bus.vga_hsync;
      if (prev && !cur) begin
        if (t0 < 0) t0 = n;
        else        t2 = n;
      end
      if (!prev && cur && t0 >= 0 && t1 < 0) t1 = n;
      prev = cur;
    end
    low = (t0 < 0 || t1 < 0) ? -1 : t1 - t0;
    per = (t0 < 0 || t2 < 0) ? -1 : t2 - t0;
  endtask

  int lo, pr;

  initial begin
    bus.slv_reg0 = '0;
    bus.slv_reg1 = '0;
    bus.slv_reg2 = '0;
    bus.slv_reg3 = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", 32'(rgb_now()), 32'h000);
    check("rst_hs", 32'(bus.vga_hsync), 32'd1);
    check("rst_vs", 32'(bus.vga_vsync), 32'd1);
    check("rst_fs", 32'(bus.frame_start), 32'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;

    bus.slv_reg0 = 32'd3;
    bus.slv_reg1 = 32'd8;
    bus.slv_reg2 = 32'h0000_0F00;
    bus.slv_reg3 = 32'h0000_0101;

    sync_shape(1'b0, lo, pr);
    check("hs_low", 32'(lo), 32'd16);
    check("hs_per", 32'(pr), 32'd96);
    sync_shape(1'b1, lo, pr);
    check("vs_low", 32'(lo), 32'd192);
    check("vs_per", 32'(pr), 32'd1536);

    wait_frame();
    expect_px("t2_tgt3", 5, 3, 12'hFFF);
    expect_px("t2_blank", 20, 3, 12'h000);
    expect_px("t2_tgt4", 5, 4, 12'hFFF);
    expect_px("t2_bg", 5, 6, 12'h000);
    expect_px("t2_det8", 5, 8, 12'hF00);
    expect_px("t2_det9", 5, 9, 12'hF00);

    bus.slv_reg0 = 32'd2;
    bus.slv_reg1 = 32'd5;
    bus.slv_reg3 = 32'h0000_0301;
    wait_frame();
    expect_px("t3_tol5", 0, 5, 12'h0F0);
    expect_px("t3_tol6", 15, 6, 12'h0F0);

    bus.slv_reg1 = 32'd3;
    wait_frame();
    expect_px("t3_prio", 4, 3, 12'hFFF);
    expect_px("t3_near", 4, 4, 12'h0F0);

    bus.slv_reg1 = 32'd6;
    wait_frame();
    expect_px("t3_out", 0, 6, 12'hF00);

    bus.slv_reg1 = 32'd8;
    bus.slv_reg3 = 32'h0000_0101;
    wait_frame();
    expect_px("t4_row1", 3, 1, 12'h000);
    bus.slv_reg1 = 32'd4;
    expect_px("t4_old4", 3, 4, 12'h000);
    expect_px("t4_old8", 3, 8, 12'hF00);
    wait_frame();
    expect_px("t4_new4", 3, 4, 12'hF00);
    expect_px("t4_new8", 3, 8, 12'h000);

    bus.slv_reg1 = 32'd600;
    wait_frame();
    expect_px("t5_row10", 7, 10, 12'h000);
    expect_px("t5_clamp", 7, 11, 12'hF00);

    bus.slv_reg0 = 32'd600;
    bus.slv_reg1 = 32'd2;
    wait_frame();
    expect_px("t5_tclamp", 7, 11, 12'hFFF);

    bus.slv_reg0 = 32'd2;
    bus.slv_reg3 = 32'h0000_0100;
    wait_frame();
    expect_px("t5_disabled", 7, 2, 12'h000);

    bus.slv_reg3 = 32'h0000_0101;
    wait_frame();
    expect_px("t6_pre", 8, 2, 12'hFFF);
    rst_n = 1'b0;
    #1;
    check("t6_rgb", 32'(rgb_now()), 32'h000);
    check("t6_hs", 32'(bus.vga_hsync), 32'd1);
    check("t6_vs", 32'(bus.vga_vsync), 32'd1);
    check("t6_fs", 32'(bus.frame_start), 32'd0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;

    wait_m(75);
    check("t6_hs_pre", 32'(bus.vga_hsync), 32'd1);
    wait_m(76);
    check("t6_hs_fall", 32'(bus.vga_hsync), 32'd0);
    wait_frame();
    expect_px("t6_resume", 0, 2, 12'hFFF);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
